// File: rtl/ibex_pmp_chk_arb.sv
// Round-robin arbiter that shares one PMP checker channel between several
// requesters. A winner is accepted in IDLE, its request is registered and
// driven into the checker in CHECK, and the captured fault bit is returned
// on the winner's response port in RESP.
//
// Handshake rule for both the request and response sides: a transfer happens
// in a cycle where valid and ready are both high; the requester holds its
// payload stable while valid is high and not yet accepted, and the block
// holds its response stable while rsp_valid_o is high and not yet accepted.
module ibex_pmp_chk_arb #(
  parameter int NumReq  = 4,
  parameter int ErrCntW = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumReq-1:0]      req_valid_i,
  output logic [NumReq-1:0]      req_ready_o,
  input  logic [NumReq*34-1:0]   req_addr_i,
  input  logic [NumReq*2-1:0]    req_type_i,
  input  logic [NumReq*2-1:0]    req_priv_i,
  output logic [NumReq-1:0]      rsp_valid_o,
  output logic                   rsp_err_o,
  input  logic [NumReq-1:0]      rsp_ready_i,
  output logic [33:0]            pmp_req_addr_o,
  output logic [1:0]             pmp_req_type_o,
  output logic [1:0]             pmp_priv_o,
  input  logic                   pmp_req_err_i,
  input  logic                   pmp_cfg_wr_i,
  output logic                   busy_o,
  output logic [ErrCntW-1:0]     err_cnt_o,
  output logic [1:0]             dbg_state_o
);

  // Encodings match the core's pmp_req_e / priv_lvl_e enumerations.
  localparam logic [1:0] PMP_ACC_READ = 2'b10;
  localparam logic [1:0] PRIV_LVL_M   = 2'b11;

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam logic [IdxW-1:0]    LastIdx = IdxW'(NumReq - 1);
  localparam logic [ErrCntW-1:0] ErrMax  = {ErrCntW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e              r_state;
  logic [IdxW-1:0]     r_rr_ptr;
  logic [IdxW-1:0]     r_win;
  logic [33:0]         r_addr;
  logic [1:0]          r_type;
  logic [1:0]          r_priv;
  logic                r_err;
  logic [ErrCntW-1:0]  r_err_cnt;

  logic                w_found;
  logic [IdxW-1:0]     w_win;
  logic                w_rsp_hs;

  // Pick the first valid requester at or above rr_ptr, wrapping modulo NumReq.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NumReq; i++) begin
      int j;
      j = int'(r_rr_ptr) + i;
      if (j >= NumReq) j = j - NumReq;
      if (!w_found && req_valid_i[j]) begin
        w_found = 1'b1;
        w_win   = IdxW'(j);
      end
    end
  end

  // Grant is combinational so the requester sees acceptance in the same cycle.
  always_comb begin
    req_ready_o = '0;
    if (r_state == S_IDLE && w_found) req_ready_o[w_win] = 1'b1;
  end

  // Only the current winner's response port is driven; error is masked otherwise.
  always_comb begin
    rsp_valid_o = '0;
    if (r_state == S_RESP) rsp_valid_o[r_win] = 1'b1;
  end

  assign w_rsp_hs       = (r_state == S_RESP) && rsp_ready_i[r_win];
  assign rsp_err_o      = (r_state == S_RESP) && r_err;
  assign busy_o         = (r_state != S_IDLE);
  assign err_cnt_o      = r_err_cnt;
  assign pmp_req_addr_o = r_addr;
  assign pmp_req_type_o = r_type;
  assign pmp_priv_o     = r_priv;
  assign dbg_state_o    = r_state;

  // Arbitration FSM: accept, check (re-checking across config writes), respond.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_win     <= '0;
      r_addr    <= '0;
      r_type    <= PMP_ACC_READ;
      r_priv    <= PRIV_LVL_M;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_win   <= w_win;
            r_addr  <= req_addr_i[int'(w_win)*34 +: 34];
            r_type  <= req_type_i[int'(w_win)*2 +: 2];
            r_priv  <= req_priv_i[int'(w_win)*2 +: 2];
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          // A config write this cycle makes the checker result stale; retry.
          if (!pmp_cfg_wr_i) begin
            r_err   <= pmp_req_err_i;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_rr_ptr <= (r_win == LastIdx) ? '0 : r_win + 1'b1;
            if (r_err && (r_err_cnt != ErrMax)) r_err_cnt <= r_err_cnt + 1'b1;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_pmp_chk_arb.sv
// Directed bench for ibex_pmp_chk_arb (NumReq = 4, ErrCntW = 2).
// Inputs change just after the falling edge; outputs are checked 1 ns later,
// well away from the rising edge.
module tb_ibex_pmp_chk_arb;

  localparam int NumReq  = 4;
  localparam int ErrCntW = 2;

  localparam logic [1:0] EXEC  = 2'b00;
  localparam logic [1:0] WRITE = 2'b01;
  localparam logic [1:0] READ  = 2'b10;
  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NumReq-1:0]      req_valid;
  logic [NumReq-1:0]      req_ready;
  logic [NumReq*34-1:0]   req_addr;
  logic [NumReq*2-1:0]    req_type;
  logic [NumReq*2-1:0]    req_priv;
  logic [NumReq-1:0]      rsp_valid;
  logic                   rsp_err;
  logic [NumReq-1:0]      rsp_ready;
  logic [33:0]            pmp_addr;
  logic [1:0]             pmp_type;
  logic [1:0]             pmp_priv;
  logic                   pmp_err;
  logic                   cfg_wr;
  logic                   busy;
  logic [ErrCntW-1:0]     err_cnt;
  logic [1:0]             dbg_state;

  int n_chk  = 0;
  int n_fail = 0;

  ibex_pmp_chk_arb #(.NumReq(NumReq), .ErrCntW(ErrCntW)) u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_addr_i     (req_addr),
    .req_type_i     (req_type),
    .req_priv_i     (req_priv),
    .rsp_valid_o    (rsp_valid),
    .rsp_err_o      (rsp_err),
    .rsp_ready_i    (rsp_ready),
    .pmp_req_addr_o (pmp_addr),
    .pmp_req_type_o (pmp_type),
    .pmp_priv_o     (pmp_priv),
    .pmp_req_err_i  (pmp_err),
    .pmp_cfg_wr_i   (cfg_wr),
    .busy_o         (busy),
    .err_cnt_o      (err_cnt),
    .dbg_state_o    (dbg_state)
  );

  // Driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic [33:0] a, input logic [1:0] t,
                         input logic [1:0] p);
    req_addr[i*34 +: 34] = a;
    req_type[i*2 +: 2]   = t;
    req_priv[i*2 +: 2]   = p;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_rsp_err"},   64'(rsp_err),   64'(0));
    chk({tag, "_busy"},      64'(busy),      64'(0));
    chk({tag, "_err_cnt"},   64'(err_cnt),   64'(0));
    chk({tag, "_pmp_addr"},  64'(pmp_addr),  64'(0));
    chk({tag, "_pmp_type"},  64'(pmp_type),  64'(READ));
    chk({tag, "_pmp_priv"},  64'(pmp_priv),  64'(PRIV_M));
    chk({tag, "_state"},     64'(dbg_state), 64'(0));
  endtask

  logic [3:0] rr_order [5];
  logic [1:0] sat_exp  [5];

  initial begin
    rr_order = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    sat_exp  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    rst = 1'b1; req_valid = '0; req_addr = '0; req_type = '0; req_priv = '0;
    rsp_ready = '0; pmp_err = 1'b0; cfg_wr = 1'b0;
    for (int i = 0; i < NumReq; i++) set_req(i, 34'h0_1000 * 34'(i + 1), EXEC, PRIV_S);

    // ---- reset values ----
    step(); step(); settle();
    chk_reset_vals("rst");
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    step(); rst = 1'b0;

    // ---- single request ----
    set_req(0, 34'h0_8000_0000, READ, PRIV_M);
    req_valid = 4'b0001; rsp_ready = 4'b0001; settle();
    chk("s1_ready_T", 64'(req_ready), 64'b0001);
    chk("s1_busy_T", 64'(busy), 64'(0));
    step(); req_valid = '0; pmp_err = 1'b0; settle();
    chk("s1_busy_T1", 64'(busy), 64'(1));
    chk("s1_rsp_T1", 64'(rsp_valid), 64'(0));
    chk("s1_addr_T1", 64'(pmp_addr), 64'h0_8000_0000);
    chk("s1_type_T1", 64'(pmp_type), 64'(READ));
    chk("s1_priv_T1", 64'(pmp_priv), 64'(PRIV_M));
    step(); settle();
    chk("s1_rsp_T2", 64'(rsp_valid), 64'b0001);
    chk("s1_err_T2", 64'(rsp_err), 64'(0));
    chk("s1_ready_T2", 64'(req_ready), 64'(0));
    step(); settle();
    chk("s1_busy_T3", 64'(busy), 64'(0));
    chk("s1_rsp_T3", 64'(rsp_valid), 64'(0));
    chk("s1_cnt_T3", 64'(err_cnt), 64'(0));

    // ---- round-robin fairness from a fresh pointer ----
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < NumReq; i++) set_req(i, 34'h0_1000 * 34'(i + 1), WRITE, PRIV_U);
    req_valid = 4'b1111; rsp_ready = 4'b1111; pmp_err = 1'b0;
    for (int g = 0; g < 5; g++) begin
      settle();
      chk("rr_grant", 64'(req_ready), 64'(4'b0001 << rr_order[g]));
      step(); settle();
      chk("rr_check_ready", 64'(req_ready), 64'(0));
      chk("rr_check_addr", 64'(pmp_addr), 64'(34'h0_1000 * 34'(rr_order[g] + 1)));
      step(); settle();
      chk("rr_rsp", 64'(rsp_valid), 64'(4'b0001 << rr_order[g]));
      step();
    end
    req_valid = '0;
    // pointer is now 1

    // ---- config write during CHECK ----
    set_req(0, 34'h2_0000_0004, WRITE, PRIV_U);
    req_valid = 4'b0001; rsp_ready = 4'b1111; settle();
    chk("cw_ready_T", 64'(req_ready), 64'b0001);
    step(); req_valid = '0; cfg_wr = 1'b1; pmp_err = 1'b0; settle();
    chk("cw_rsp_T1", 64'(rsp_valid), 64'(0));
    step(); settle();
    chk("cw_rsp_T2", 64'(rsp_valid), 64'(0));
    chk("cw_busy_T2", 64'(busy), 64'(1));
    step(); cfg_wr = 1'b0; pmp_err = 1'b1; settle();
    chk("cw_rsp_T3", 64'(rsp_valid), 64'(0));
    chk("cw_addr_T3", 64'(pmp_addr), 64'h2_0000_0004);
    chk("cw_type_T3", 64'(pmp_type), 64'(WRITE));
    chk("cw_priv_T3", 64'(pmp_priv), 64'(PRIV_U));
    step(); cfg_wr = 1'b1; pmp_err = 1'b0; settle();
    chk("cw_rsp_T4", 64'(rsp_valid), 64'b0001);
    chk("cw_err_T4", 64'(rsp_err), 64'(1));
    step(); cfg_wr = 1'b0; settle();
    chk("cw_cnt_T5", 64'(err_cnt), 64'(1));
    chk("cw_rsp_T5", 64'(rsp_valid), 64'(0));
    chk("cw_err_T5", 64'(rsp_err), 64'(0));

    // ---- response backpressure, pointer at 1 ----
    set_req(1, 34'h1_2345_6788, READ, PRIV_S);
    set_req(2, 34'h0_0000_0040, EXEC, PRIV_M);
    req_valid = 4'b0110; rsp_ready = 4'b0000; settle();
    chk("bp_grant1", 64'(req_ready), 64'b0010);
    step(); req_valid = 4'b0100; pmp_err = 1'b1; settle();
    chk("bp_ready_chk", 64'(req_ready), 64'(0));
    for (int c = 0; c < 5; c++) begin
      step(); rsp_ready = 4'b1101; cfg_wr = c[0]; pmp_err = 1'b0; settle();
      chk("bp_hold_valid", 64'(rsp_valid), 64'b0010);
      chk("bp_hold_err", 64'(rsp_err), 64'(1));
      chk("bp_hold_ready", 64'(req_ready), 64'(0));
    end
    step(); rsp_ready = 4'b0010; cfg_wr = 1'b0; settle();
    chk("bp_hs_valid", 64'(rsp_valid), 64'b0010);
    step(); rsp_ready = 4'b0100; settle();
    chk("bp_grant2", 64'(req_ready), 64'b0100);
    chk("bp_cnt", 64'(err_cnt), 64'(2));
    step(); req_valid = '0; pmp_err = 1'b0; settle();
    chk("bp_addr2", 64'(pmp_addr), 64'h0_0000_0040);
    step(); settle();
    chk("bp_rsp2", 64'(rsp_valid), 64'b0100);
    chk("bp_err2", 64'(rsp_err), 64'(0));
    step();
    // pointer is now 3

    // ---- reset during CHECK ----
    set_req(3, 34'h3_FFFF_FFFC, WRITE, PRIV_S);
    req_valid = 4'b1000; rsp_ready = 4'b1111; settle();
    chk("rm_grant", 64'(req_ready), 64'b1000);
    step(); req_valid = '0; rst = 1'b1; settle();
    chk("rm_busy_T1", 64'(busy), 64'(1));
    step(); rst = 1'b0; settle();
    chk_reset_vals("rm");
    step(); settle();
    chk("rm_rsp_T3", 64'(rsp_valid), 64'(0));
    req_valid = 4'b1111; settle();
    chk("rm_ptr0", 64'(req_ready), 64'b0001);
    step(); req_valid = '0; step(); step();
    // pointer is now 1, counter 0

    // ---- counter saturation ----
    set_req(1, 34'h0_0000_1000, READ, PRIV_U);
    rsp_ready = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      req_valid = 4'b0010; settle();
      chk("sat_grant", 64'(req_ready), 64'b0010);
      step(); req_valid = '0; pmp_err = 1'b1;
      step(); settle();
      chk("sat_err", 64'(rsp_err), 64'(1));
      step(); settle();
      chk("sat_cnt", 64'(err_cnt), 64'(sat_exp[k]));
    end
    pmp_err = 1'b0;
    step(); settle();
    chk("sat_cnt_hold", 64'(err_cnt), 64'(3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_pmp_chk_arb.md
# ibex_pmp_chk_arb

Shares one PMP checker channel between several requesters (e.g. DMA ports, debug bus master) that lack a dedicated channel. Round-robin arbitrates, registers the winning request, drives it into the checker channel, captures the fault result and returns it on a per-requester valid/ready response port. Sits between the requesters and one channel of the PMP checker, in the same clock domain as the CSR file.

## Interface
- NumReq, 4: number of requesters, 2..8.
- ErrCntW, 16: width of the saturating fault counter.

- clk_i  in  1  core clock.
- rst_i  in  1  synchronous reset, active-high.
- req_valid_i  in  NumReq  request valid, one bit per requester.
- req_ready_o  out  NumReq  request accepted this cycle, one-hot or zero.
- req_addr_i  in  NumReq x 34  physical address per requester.
- req_type_i  in  NumReq x pmp_req_e  access type (EXEC/WRITE/READ).
- req_priv_i  in  NumReq x priv_lvl_e  privilege of access.
- rsp_valid_o  out  NumReq  response valid, at most one bit set.
- rsp_err_o  out  1  access fault for the responding requester.
- rsp_ready_i  in  NumReq  response accepted.
- pmp_req_addr_o  out  34  address driven into checker channel.
- pmp_req_type_o  out  pmp_req_e  type into checker channel.
- pmp_priv_o  out  priv_lvl_e  privilege into checker channel.
- pmp_req_err_i  in  1  combinational fault result from checker for the driven request.
- pmp_cfg_wr_i  in  1  a PMP cfg/addr/mseccfg CSR write takes effect this cycle.
- busy_o  out  1  FSM not in IDLE.
- err_cnt_o  out  ErrCntW  number of faulted responses delivered, saturating.

## Operation
- FSM states: IDLE, CHECK, RESP.
- IDLE: if any req_valid_i set, pick winner = first set bit scanning from rr_ptr upward modulo NumReq. Assert req_ready_o[winner] combinationally in same cycle; latch addr/type/priv and winner id; go CHECK. No valid → stay IDLE, req_ready_o = 0.
- CHECK: pmp_req_*_o/pmp_priv_o driven from latched registers (held constant in all states; value after reset is addr 0, type READ, priv M). If pmp_cfg_wr_i = 0: capture pmp_req_err_i into err register, go RESP. If pmp_cfg_wr_i = 1: discard result, stay in CHECK one more cycle (re-check against new config); repeats while pmp_cfg_wr_i stays high.
- RESP: rsp_valid_o[winner] = 1, rsp_err_o = err register. On rsp_ready_i[winner]: rr_ptr ← (winner + 1) mod NumReq; if err = 1 and err_cnt_o < max, err_cnt_o increments; go IDLE. rsp_ready_i bits of non-winners are ignored. A pmp_cfg_wr_i during RESP does not alter the delivered result.
- req_ready_o is 0 in CHECK and RESP; no request accepted until the prior response handshakes.
- rsp_err_o is 0 whenever no rsp_valid_o bit is set.
- Requesters must hold req_* stable while req_valid_i is high and not accepted; the block does not check this.
- err_cnt_o saturates at 2^ErrCntW−1, never wraps.

## Timing
- Reset values: state IDLE, rr_ptr 0, req_ready_o 0, rsp_valid_o 0, rsp_err_o 0, busy_o 0, err_cnt_o 0, latched request addr 0/READ/M.
- Reset mid-operation: any in-flight request is dropped without response; next cycle is IDLE.
- Latency: accept in cycle T, checker driven in T+1, rsp_valid_o in T+2 (plus one cycle per cycle of pmp_cfg_wr_i high in CHECK).
- Minimum issue interval 3 cycles with rsp_ready_i held high.
- pmp_req_err_i sampled only in CHECK; checker path is combinational, so the full PMP compare sits in one cycle from latched registers.
- busy_o = 1 from T+1 through the RESP handshake cycle.

## Test plan
- Single request: req_valid_i = 0001, addr 0x0_8000_0000, READ, M, checker err 0 → req_ready_o = 0001 at T, rsp_valid_o = 0001 with rsp_err_o 0 at T+2, err_cnt_o 0.
- Round-robin fairness: all four valid continuously, rsp_ready_i all high → grant order 0,1,2,3,0 with responses every 3 cycles.
- Config change: pmp_cfg_wr_i high for 2 cycles during CHECK, checker err 0 then 1 after write → response at T+4 with rsp_err_o 1, err_cnt_o 1.
- Response backpressure: rsp_ready_i low 5 cycles while requester 2 also valid → rsp_valid_o held with stable rsp_err_o, req_ready_o stays 0, requester 2 granted only after handshake.
- Reset mid-CHECK: assert rst_i in T+1 → rsp_valid_o never asserted, all outputs at reset values next cycle, rr_ptr 0.
- Counter saturation with ErrCntW = 2: five faulted responses → err_cnt_o 1,2,3,3,3.
